// File: rtl/arch_defs_pkg.sv
// Shared architecture constants and types for the memory map.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [2:0] {REG_NONE, REG_RAM, REG_VRAM, REG_MMIO, REG_ROM} mem_region_e;
  typedef enum logic [1:0] {WM_WRITE, WM_SET, WM_CLEAR, WM_TOGGLE} mmio_wmode_e;

  localparam logic [3:0] MMIO_STATUS_OFF = 4'hF;

  // Memories shared one address bus; it must cover both RAM and the 4K regions.
  function automatic int mem_addr_bits(input int ram_addr_bits);
    return (ram_addr_bits > 12) ? ram_addr_bits : 12;
  endfunction

endpackage

// File: rtl/mmio_out_bank.sv
// Bank of memory-mapped output registers with write/set/clear/toggle update modes.
module mmio_out_bank
  import arch_defs_pkg::*;
#(
  parameter int DW        = 8,
  parameter int NUM_PORTS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [3:0]              sel,
  input  mmio_wmode_e             wmode,
  input  logic [DW-1:0]           wdata,
  output logic [NUM_PORTS*DW-1:0] out_ports,
  output logic [NUM_PORTS-1:0]    out_load
);

  function automatic logic [DW-1:0] apply_mode(input mmio_wmode_e mode,
                                               input logic [DW-1:0] cur,
                                               input logic [DW-1:0] din);
    case (mode)
      WM_SET:    return cur | din;
      WM_CLEAR:  return cur & ~din;
      WM_TOGGLE: return cur ^ din;
      default:   return din;
    endcase
  endfunction

  // out_load is registered alongside the port so the pulse lines up with the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_ports <= '0;
      out_load  <= '0;
    end else begin
      out_load <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (wr_en && sel == 4'(k)) begin
          out_ports[k*DW +: DW] <= apply_mode(wmode, out_ports[k*DW +: DW], wdata);
          out_load[k]           <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_map_ctrl.sv
// Address decoder and MMIO controller between the cpu and RAM/VRAM/ROM.
// Every read returns exactly one cycle after cpu_read, aligned to the sync memories.
module mem_map_ctrl
  import arch_defs_pkg::*;
#(
  parameter int         DATA_WIDTH    = arch_defs_pkg::DATA_WIDTH,
  parameter int         ADDR_WIDTH    = arch_defs_pkg::ADDR_WIDTH,
  parameter int         RAM_ADDR_BITS = 13,
  parameter logic [3:0] VRAM_PREFIX   = 4'hD,
  parameter logic [3:0] MMIO_PREFIX   = 4'hE,
  parameter logic [3:0] ROM_PREFIX    = 4'hF,
  parameter int         NUM_OUT_PORTS = 4,
  localparam int        MEM_AW        = mem_addr_bits(RAM_ADDR_BITS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_WIDTH-1:0]               cpu_addr,
  input  logic                                cpu_read,
  input  logic                                cpu_write,
  input  logic [DATA_WIDTH-1:0]               cpu_wdata,
  output logic [DATA_WIDTH-1:0]               cpu_rdata,
  output logic                                cpu_rvalid,
  output logic                                ram_we,
  output logic                                vram_we,
  output logic [MEM_AW-1:0]                   mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic [DATA_WIDTH-1:0]               ram_rdata,
  input  logic [DATA_WIDTH-1:0]               vram_rdata,
  input  logic [DATA_WIDTH-1:0]               rom_rdata,
  output logic [NUM_OUT_PORTS*DATA_WIDTH-1:0] out_ports,
  output logic [NUM_OUT_PORTS-1:0]            out_load,
  output logic                                bus_error
);

  localparam logic [3:0] NPORTS = 4'(NUM_OUT_PORTS);

  mem_region_e           region;
  mem_region_e           rd_sel_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] mmio_rdata_q;
  logic [DATA_WIDTH-1:0] mmio_rd;
  logic [3:0]            hi;
  logic [3:0]            port_idx;
  logic                  is_status, port_hit, port_wr, rd_en, err_set, status_clr;

  assign hi       = cpu_addr[ADDR_WIDTH-1 -: 4];
  assign port_idx = cpu_addr[3:0];

  always_comb begin
    region = REG_NONE;
    if (cpu_addr[ADDR_WIDTH-1:RAM_ADDR_BITS] == '0) region = REG_RAM;
    else if (hi == VRAM_PREFIX)                     region = REG_VRAM;
    else if (hi == MMIO_PREFIX)                     region = REG_MMIO;
    else if (hi == ROM_PREFIX)                      region = REG_ROM;
  end

  assign is_status  = (region == REG_MMIO) && (port_idx == MMIO_STATUS_OFF);
  assign port_hit   = (region == REG_MMIO) && (port_idx < NPORTS);
  assign port_wr    = cpu_write && port_hit;
  assign rd_en      = cpu_read && !cpu_write;
  assign status_clr = cpu_write && is_status;
  // A simultaneous read+write is a protocol error even though the write still lands.
  assign err_set    = (cpu_write && (region == REG_ROM || region == REG_NONE))
                   || (rd_en && region == REG_NONE)
                   || (cpu_read && cpu_write);

  assign ram_we    = cpu_write && (region == REG_RAM);
  assign vram_we   = cpu_write && (region == REG_VRAM);
  assign mem_addr  = cpu_addr[MEM_AW-1:0];
  assign mem_wdata = cpu_wdata;

  always_comb begin
    mmio_rd = '0;
    if (is_status) begin
      mmio_rd = {{(DATA_WIDTH-1){1'b0}}, bus_error};
    end else if (port_hit) begin
      for (int k = 0; k < NUM_OUT_PORTS; k++)
        if (port_idx == 4'(k)) mmio_rd = out_ports[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sel_q     <= REG_NONE;
      rvalid_q     <= 1'b0;
      mmio_rdata_q <= '0;
      bus_error    <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) begin
        rd_sel_q     <= region;
        mmio_rdata_q <= mmio_rd;
      end
      if (err_set)         bus_error <= 1'b1;
      else if (status_clr) bus_error <= 1'b0;
    end
  end

  assign cpu_rvalid = rvalid_q;

  always_comb begin
    cpu_rdata = '0;
    if (rvalid_q) begin
      case (rd_sel_q)
        REG_RAM:  cpu_rdata = ram_rdata;
        REG_VRAM: cpu_rdata = vram_rdata;
        REG_MMIO: cpu_rdata = mmio_rdata_q;
        REG_ROM:  cpu_rdata = rom_rdata;
        default:  cpu_rdata = '0;
      endcase
    end
  end

  mmio_out_bank #(
    .DW        (DATA_WIDTH),
    .NUM_PORTS (NUM_OUT_PORTS)
  ) u_out_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (port_wr),
    .sel       (port_idx),
    .wmode     (mmio_wmode_e'(cpu_addr[5:4])),
    .wdata     (cpu_wdata),
    .out_ports (out_ports),
    .out_load  (out_load)
  );

endmodule
